stack_arbiter: RTL
==================

# stack_arbiter

Round-robin arbiter that shares one `Stack` instance (LIFO, `STACK_DEPTH` x `WORD_LEN`) between `NUM_REQ` independent requesters. Each requester issues push or pop transactions through a req/ack handshake. The arbiter serializes them into single-cycle `push`/`pop` strobes on the stack port, returns popped data, and flags overflow/underflow attempts. It sits between the client blocks and the stack; only the arbiter drives the stack's `push`, `pop` and `data_in`.

## Interface
- `NUM_REQ`, 4, number of requesters (2..8)
- `WORD_LEN`, 8, data word width; must match the attached stack
- `clk`  in  1  clock; all state updates on posedge
- `rstn`  in  1  synchronous reset, active-high (asserted = 1); same name and polarity as the attached stack
- `req`  in  NUM_REQ  per-requester request level
- `req_op`  in  NUM_REQ  per-requester operation: 0 = push, 1 = pop
- `req_data`  in  NUM_REQ*WORD_LEN  push data; requester i at bits [i*WORD_LEN +: WORD_LEN]
- `gnt`  out  NUM_REQ  one-hot grant, held from grant until ack; reset 0
- `ack`  out  NUM_REQ  one-hot one-cycle completion pulse; reset 0
- `rsp_err`  out  1  valid with ack: push to full stack or pop from empty stack; reset 0
- `rsp_data`  out  WORD_LEN  popped word, valid with ack on a successful pop, else 0; reset 0
- `stk_push`, `stk_pop`  out  1 each  stack strobes; never both high; reset 0
- `stk_data_in`  out  WORD_LEN  stack write data; reset 0
- `stk_data_out`  in  WORD_LEN  stack read data
- `stk_full`, `stk_empty`  in  1 each  stack status

## Operation
- FSM states: IDLE, ISSUE, COMPLETE. Reset enters IDLE.
- IDLE:
  - If any `req` is high, select the winner by round-robin, starting at `rr_ptr` and searching upward with wrap.
  - Latch the winner's index, op and data. Assert its `gnt` and set `rr_ptr` = winner+1 mod NUM_REQ.
  - Sample `stk_full` (push) or `stk_empty` (pop). If the op would fail, latch error and go to COMPLETE with no strobe; otherwise go to ISSUE.
- ISSUE: drive `stk_push` (with `stk_data_in` = latched data) or `stk_pop` high for exactly this cycle, then go to COMPLETE.
- COMPLETE:
  - Pulse `ack[winner]`. Drive `rsp_err` = latched error.
  - Drive `rsp_data` = `stk_data_out` for a successful pop (the stack updates `data_out` at the ISSUE edge); otherwise drive 0.
  - Clear `gnt`, go to IDLE.
- Requesters hold `req`, `req_op` and `req_data` stable until ack. A `req` deasserted after grant does not abort the transaction; the ack is still issued.
- A requester re-requesting immediately after its ack competes normally; round-robin guarantees every other pending requester is served first.
- Reset mid-transaction: abort; no strobe, ack or err in the reset cycle; `rr_ptr` = 0. The stack contents are reset by the shared `rstn`.

## Timing
- Grant in IDLE cycle T; stack strobe in T+1; ack/data in T+2. Error transactions ack in T+1.
- Maximum throughput: one transaction per 3 cycles; next grant can occur in cycle T+3.
- Stack status is sampled only in IDLE. Because no other agent drives the stack, status cannot change between the sample and the strobe.
- `gnt` is high in T..T+1 (T only for error transactions); `ack` is high only in the final cycle.

## Configuration
- `STACK_ARB_PRIORITY_EN` defined:
  - Requester 0 has fixed highest priority; it wins whenever its `req` is high in IDLE.
  - The remaining requesters are round-robin among themselves.
  - `rr_ptr` never points to 0 and skips it on wrap.
- Undefined: pure round-robin over all NUM_REQ requesters, as described above.

## Test plan
- Single push: req[1]=1, op=0, data=8'h5A, stack empty -> gnt[1] in T..T+1; stk_push=1 with stk_data_in=8'h5A in T+1; ack[1] in T+2; rsp_err=0.
- Pop after push: req[2] pops -> stk_pop in T+1; ack[2] with rsp_data=8'h5A and rsp_err=0 in T+2; stk_empty=1 afterwards.
- Fairness: all four req high continuously, `rr_ptr`=0 -> grants in order 0,1,2,3,0 at 3-cycle spacing.
  - With `STACK_ARB_PRIORITY_EN`: all grants go to 0 while req[0] is held.
- Boundary: 8 pushes fill the stack, then a 9th push -> no stk_push, ack in T+1 with rsp_err=1. A pop on an empty stack -> rsp_err=1, rsp_data=0.
- Reset mid-operation: assert rstn in the ISSUE cycle -> no stk strobe that cycle, all outputs 0 next cycle, FSM in IDLE, next grant goes to requester 0.

Source files
------------

// File: rtl/stack_arbiter.sv
// stack_arbiter
// Round-robin arbiter that lets NUM_REQ requesters share one LIFO stack.
// Each requester's push or pop becomes a single-cycle strobe on the stack port.
// Popped data and overflow/underflow errors are returned alongside a one-cycle ack.
// Optional build macro: STACK_ARB_PRIORITY_EN. When it is defined, requester 0
// has fixed top priority and requesters 1..NUM_REQ-1 are round-robin among
// themselves. When it is undefined, all requesters are round-robin.
module stack_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int WORD_LEN = 8
) (
  input  logic                        clk_i,
  input  logic                        rstn_i,
  input  logic [NUM_REQ-1:0]          req_i,
  input  logic [NUM_REQ-1:0]          req_op_i,
  input  logic [NUM_REQ*WORD_LEN-1:0] req_data_i,
  output logic [NUM_REQ-1:0]          gnt_o,
  output logic [NUM_REQ-1:0]          ack_o,
  output logic                        rsp_err_o,
  output logic [WORD_LEN-1:0]         rsp_data_o,
  output logic                        stk_push_o,
  output logic                        stk_pop_o,
  output logic [WORD_LEN-1:0]         stk_data_in_o,
  input  logic [WORD_LEN-1:0]         stk_data_out_i,
  input  logic                        stk_full_i,
  input  logic                        stk_empty_i
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    COMPLETE = 2'd2
  } state_t;

`ifdef STACK_ARB_PRIORITY_EN
  // Requester 0 never takes part in the rotation, so the pointer starts at 1.
  localparam logic [IDX_W-1:0] RR_RESET = IDX_W'(1);
`else
  localparam logic [IDX_W-1:0] RR_RESET = '0;
`endif

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     rrPtr_q, rrPtr_d;
  logic [IDX_W-1:0]     winner_q, winner_d;
  logic                 opIsPop_q, opIsPop_d;
  logic [WORD_LEN-1:0]  data_q, data_d;
  logic                 err_q, err_d;

  logic                 anyReq;
  logic [IDX_W-1:0]     pickIdx;
  logic                 pickOpIsPop;
  logic                 pickErr;

`ifdef STACK_ARB_PRIORITY_EN
  // Requester 0 wins outright. Otherwise, search 1..NUM_REQ-1 upward from ptr, wrapping past 0.
  function automatic logic [IDX_W-1:0] rrPick(input logic [NUM_REQ-1:0] reqs,
                                              input logic [IDX_W-1:0]   ptr);
    logic [IDX_W-1:0] pick;
    logic [IDX_W-1:0] cand;
    logic             found;
    int               idx;
    pick  = '0;
    found = 1'b0;
    if (!reqs[0]) begin
      for (int off = 0; off < NUM_REQ - 1; off++) begin
        idx  = 1 + ((int'(ptr) - 1 + off) % (NUM_REQ - 1));
        cand = IDX_W'(idx);
        if (!found && reqs[cand]) begin
          found = 1'b1;
          pick  = cand;
        end
      end
    end
    return pick;
  endfunction

  // A win by requester 0 leaves the rotation untouched; otherwise step past the winner, skipping 0.
  function automatic logic [IDX_W-1:0] rrAdvance(input logic [IDX_W-1:0] win,
                                                 input logic [IDX_W-1:0] cur);
    logic [IDX_W-1:0] nxt;
    if (win == '0) begin
      nxt = cur;
    end else if (int'(win) == NUM_REQ - 1) begin
      nxt = IDX_W'(1);
    end else begin
      nxt = IDX_W'(int'(win) + 1);
    end
    return nxt;
  endfunction
`else
  // Search all requesters upward from ptr with wrap; the first one asserting req wins.
  function automatic logic [IDX_W-1:0] rrPick(input logic [NUM_REQ-1:0] reqs,
                                              input logic [IDX_W-1:0]   ptr);
    logic [IDX_W-1:0] pick;
    logic [IDX_W-1:0] cand;
    logic             found;
    int               idx;
    pick  = '0;
    found = 1'b0;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx  = (int'(ptr) + off) % NUM_REQ;
      cand = IDX_W'(idx);
      if (!found && reqs[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
    return pick;
  endfunction

  // The winner becomes lowest priority: the pointer moves just past it, modulo NUM_REQ.
  function automatic logic [IDX_W-1:0] rrAdvance(input logic [IDX_W-1:0] win);
    logic [IDX_W-1:0] nxt;
    if (int'(win) == NUM_REQ - 1) begin
      nxt = '0;
    end else begin
      nxt = IDX_W'(int'(win) + 1);
    end
    return nxt;
  endfunction
`endif

  function automatic logic [NUM_REQ-1:0] oneHot(input logic [IDX_W-1:0] idx);
    logic [NUM_REQ-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

  // Pick the arbitration winner and check whether its operation can succeed on the stack.
  always_comb begin
    anyReq      = |req_i;
    pickIdx     = rrPick(req_i, rrPtr_q);
    pickOpIsPop = req_op_i[pickIdx];
    pickErr     = pickOpIsPop ? stk_empty_i : stk_full_i;
  end

  // Next-state logic: latch the winner in IDLE, strobe in ISSUE, acknowledge in COMPLETE.
  always_comb begin
    state_d   = state_q;
    rrPtr_d   = rrPtr_q;
    winner_d  = winner_q;
    opIsPop_d = opIsPop_q;
    data_d    = data_q;
    err_d     = err_q;
    unique case (state_q)
      IDLE: begin
        if (anyReq) begin
          winner_d  = pickIdx;
          opIsPop_d = pickOpIsPop;
          data_d    = req_data_i[pickIdx*WORD_LEN +: WORD_LEN];
          err_d     = pickErr;
`ifdef STACK_ARB_PRIORITY_EN
          rrPtr_d   = rrAdvance(pickIdx, rrPtr_q);
`else
          rrPtr_d   = rrAdvance(pickIdx);
`endif
          state_d   = pickErr ? COMPLETE : ISSUE;
        end
      end
      ISSUE: begin
        state_d = COMPLETE;
      end
      COMPLETE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and transaction registers; a synchronous reset aborts any transaction in flight.
  always_ff @(posedge clk_i) begin
    if (rstn_i) begin
      state_q   <= IDLE;
      rrPtr_q   <= RR_RESET;
      winner_q  <= '0;
      opIsPop_q <= 1'b0;
      data_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rrPtr_q   <= rrPtr_d;
      winner_q  <= winner_d;
      opIsPop_q <= opIsPop_d;
      data_q    <= data_d;
      err_q     <= err_d;
    end
  end

  // Output decode. Outputs are forced low while reset is asserted, so an aborted transaction emits nothing.
  always_comb begin
    gnt_o         = '0;
    ack_o         = '0;
    rsp_err_o     = 1'b0;
    rsp_data_o    = '0;
    stk_push_o    = 1'b0;
    stk_pop_o     = 1'b0;
    stk_data_in_o = '0;
    if (!rstn_i) begin
      unique case (state_q)
        IDLE: begin
          if (anyReq) begin
            gnt_o = oneHot(pickIdx);
          end
        end
        ISSUE: begin
          gnt_o      = oneHot(winner_q);
          stk_push_o = !opIsPop_q;
          stk_pop_o  = opIsPop_q;
          if (!opIsPop_q) begin
            stk_data_in_o = data_q;
          end
        end
        COMPLETE: begin
          ack_o     = oneHot(winner_q);
          rsp_err_o = err_q;
          if (opIsPop_q && !err_q) begin
            rsp_data_o = stk_data_out_i;
          end
        end
        default: begin
          gnt_o = '0;
        end
      endcase
    end
  end

  // The stack strobes are mutually exclusive, and both grant and ack are at most one-hot.
  assert property (@(posedge clk_i) !(stk_push_o && stk_pop_o));
  assert property (@(posedge clk_i) $onehot0(gnt_o));
  assert property (@(posedge clk_i) $onehot0(ack_o));

endmodule
